// File: rtl/io_input_conditioner.sv
// ---------------------------------------------------------------------------
// io_input_conditioner
//
// Front end for the memory-mapped input peripheral. Raw board switches and
// push-buttons are synchronised to i_clk and debounced. The clean switch word
// and button nibble feed the load-side input buffer. One-cycle press pulses are
// produced for interrupt or sticky-flag logic.
//
// Ports:
//   i_clk        core clock; all state changes on the rising edge
//   i_rst_n      asynchronous, active-low reset (clears every flop)
//   i_sw_raw     raw switch levels, asynchronous to i_clk
//   i_btn_raw    raw button levels, asynchronous to i_clk
//   o_io_sw      debounced switch word; all 32 bits change on the same edge
//   o_io_btn     debounced, polarity-corrected buttons (1 = pressed)
//   o_btn_pulse  one cycle high on each debounced press (0->1 of o_io_btn)
//
// Every output is a flop, or a function of flops only. There is no
// combinational path from a raw input to an output.
// ---------------------------------------------------------------------------
module io_input_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int BTN_DB_CYCLES  = 500000,
  parameter int SW_DB_CYCLES   = 500000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_sw_raw,
  input  logic [3:0]  i_btn_raw,
  output logic [31:0] o_io_sw,
  output logic [3:0]  o_io_btn,
  output logic [3:0]  o_btn_pulse
);

  localparam int BCW = $clog2(BTN_DB_CYCLES + 1);
  localparam int SCW = $clog2(SW_DB_CYCLES + 1);
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(BTN_DB_CYCLES - 1);
  localparam logic [SCW-1:0] SCNT_LAST = SCW'(SW_DB_CYCLES - 1);

  // The polarity is corrected ahead of the first synchroniser flop. Reset (0)
  // therefore always means "released" throughout the chain.
  logic [3:0] btn_in;
  assign btn_in = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;

  // Synchroniser chains
  logic [SYNC_STAGES-1:0][3:0]  btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0][31:0] sw_sync_q,  sw_sync_d;
  logic [3:0]  btn_s;
  logic [31:0] sw_s;

  always_comb begin
    btn_sync_d    = '0;
    sw_sync_d     = '0;
    btn_sync_d[0] = btn_in;
    sw_sync_d[0]  = i_sw_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      btn_sync_d[i] = btn_sync_q[i-1];
      sw_sync_d[i]  = sw_sync_q[i-1];
    end
  end

  assign btn_s = btn_sync_q[SYNC_STAGES-1];
  assign sw_s  = sw_sync_q[SYNC_STAGES-1];

  // Button debounce, with an independent counter for each bit. The counter
  // measures how long btn_s has disagreed with the output. Any cycle of
  // agreement clears it, so a glitch restarts the count.
  logic [3:0][BCW-1:0] bcnt_q, bcnt_d;
  logic [3:0]          btn_q, btn_d;
  logic [3:0]          btn_prev_q, btn_prev_d;

  always_comb begin
    bcnt_d     = bcnt_q;
    btn_d      = btn_q;
    btn_prev_d = btn_q;
    for (int k = 0; k < 4; k++) begin
      if (btn_s[k] == btn_q[k]) begin
        bcnt_d[k] = '0;
      end else if (bcnt_q[k] == BCNT_LAST) begin
        btn_d[k]  = btn_s[k];
        bcnt_d[k] = '0;
      end else begin
        bcnt_d[k] = bcnt_q[k] + BCW'(1);
      end
    end
  end

  // Switch debounce uses one counter for the whole word. The candidate
  // register sw_c holds the value being timed. Any change of any bit reloads
  // sw_c and restarts the window. The whole word is committed at once, so a
  // partially updated word is never seen.
  logic [31:0]    sw_c_q, sw_c_d;
  logic [31:0]    sw_q,   sw_d;
  logic [SCW-1:0] scnt_q, scnt_d;

  always_comb begin
    sw_c_d = sw_c_q;
    sw_d   = sw_q;
    scnt_d = scnt_q;
    if (sw_s != sw_c_q) begin
      sw_c_d = sw_s;
      scnt_d = '0;
    end else if (sw_c_q != sw_q) begin
      if (scnt_q == SCNT_LAST) begin
        sw_d   = sw_c_q;
        scnt_d = '0;
      end else begin
        scnt_d = scnt_q + SCW'(1);
      end
    end else begin
      scnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_sync_q <= '0;
      sw_sync_q  <= '0;
      bcnt_q     <= '0;
      btn_q      <= '0;
      btn_prev_q <= '0;
      sw_c_q     <= '0;
      sw_q       <= '0;
      scnt_q     <= '0;
    end else begin
      btn_sync_q <= btn_sync_d;
      sw_sync_q  <= sw_sync_d;
      bcnt_q     <= bcnt_d;
      btn_q      <= btn_d;
      btn_prev_q <= btn_prev_d;
      sw_c_q     <= sw_c_d;
      sw_q       <= sw_d;
      scnt_q     <= scnt_d;
    end
  end

  assign o_io_sw     = sw_q;
  assign o_io_btn    = btn_q;
  assign o_btn_pulse = btn_q & ~btn_prev_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_io_input_conditioner
//
// Directed scenarios are followed by a randomized phase. A reference model
// runs on every rising edge and pushes the expected {sw, btn, pulse} into
// exp_q. The model is window based: a button output flips once the last
// BTN_DB_CYCLES synchronised samples all disagree with it. The switch word
// commits once the last SW_DB_CYCLES+1 synchronised words are all equal and
// differ from the output. A monitor on the falling edge pops each entry and
// compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_io_input_conditioner;

  localparam int SYNC = 2;
  localparam int BDB  = 4;
  localparam int SDB  = 3;

  // Clock and reset
  logic        clk;
  logic        rst_n;
  logic [31:0] sw_raw;
  logic [3:0]  btn_raw;
  logic [31:0] o_io_sw;
  logic [3:0]  o_io_btn;
  logic [3:0]  o_btn_pulse;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  io_input_conditioner #(
    .SYNC_STAGES   (SYNC),
    .BTN_DB_CYCLES (BDB),
    .SW_DB_CYCLES  (SDB),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sw_raw   (sw_raw),
    .i_btn_raw  (btn_raw),
    .o_io_sw    (o_io_sw),
    .o_io_btn   (o_io_btn),
    .o_btn_pulse(o_btn_pulse)
  );

  // Result bookkeeping
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard
  logic [39:0] exp_q[$];
  logic [3:0]  dl_b[$];
  logic [31:0] dl_s[$];
  logic [3:0]  bwin[$];
  logic [31:0] swin[$];
  logic [3:0]  m_btn, m_new, m_bs, m_pulse;
  logic [31:0] m_sw, m_ss;
  bit          m_flip, m_stable;

  task automatic model_reset();
    dl_b.delete(); dl_s.delete(); bwin.delete(); swin.delete();
    for (int i = 0; i < SYNC; i++) begin
      dl_b.push_back(4'h0);
      dl_s.push_back(32'h0);
    end
    for (int i = 0; i < BDB; i++) bwin.push_back(4'h0);
    for (int i = 0; i < SDB + 1; i++) swin.push_back(32'h0);
    m_btn = 4'h0;
    m_sw  = 32'h0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
      exp_q.push_back(40'h0);
    end else begin
      // Synchronised value used at this edge: the sample taken SYNC edges ago
      m_bs = dl_b.pop_front();
      dl_b.push_back(~btn_raw);
      m_ss = dl_s.pop_front();
      dl_s.push_back(sw_raw);

      bwin.push_back(m_bs);
      if (bwin.size() > BDB) void'(bwin.pop_front());
      m_new = m_btn;
      for (int k = 0; k < 4; k++) begin
        m_flip = 1'b1;
        for (int j = 0; j < bwin.size(); j++)
          if (bwin[j][k] == m_btn[k]) m_flip = 1'b0;
        if (m_flip) m_new[k] = ~m_btn[k];
      end

      swin.push_back(m_ss);
      if (swin.size() > SDB + 1) void'(swin.pop_front());
      m_stable = 1'b1;
      for (int j = 0; j < swin.size(); j++)
        if (swin[j] != m_ss) m_stable = 1'b0;
      if (m_stable && (m_ss != m_sw)) m_sw = m_ss;

      m_pulse = m_new & ~m_btn;
      m_btn   = m_new;
      exp_q.push_back({m_sw, m_btn, m_pulse});
    end
  end

  // Monitor
  logic [39:0] mon_e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("sb_sw",    o_io_sw,             mon_e[39:8]);
      check("sb_btn",   {28'h0, o_io_btn},   {28'h0, mon_e[7:4]});
      check("sb_pulse", {28'h0, o_btn_pulse}, {28'h0, mon_e[3:0]});
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Stimulus
  int idx;
  initial begin
    rst_n   = 1'b1;
    sw_raw  = 32'hFFFF_FFFF;
    btn_raw = 4'h0;              // all pressed (active low)
    #2 rst_n = 1'b0;

    // Reset with everything asserted on the raw inputs
    ticks(3);
    check("rst_hold_sw",  o_io_sw, 32'h0);
    check("rst_hold_btn", {28'h0, o_io_btn}, 32'h0);
    check("rst_hold_pls", {28'h0, o_btn_pulse}, 32'h0);
    release_reset();
    ticks(5);
    check("rst_e5_btn", {28'h0, o_io_btn}, 32'h0);
    check("rst_e5_sw",  o_io_sw, 32'h0);
    tick();
    check("rst_e6_btn", {28'h0, o_io_btn}, 32'hF);
    check("rst_e6_sw",  o_io_sw, 32'hFFFF_FFFF);
    check("rst_e6_pls", {28'h0, o_btn_pulse}, 32'hF);
    tick();
    check("rst_e7_pls", {28'h0, o_btn_pulse}, 32'h0);

    btn_raw = 4'hF;
    sw_raw  = 32'h0;
    ticks(10);

    // Clean press and release on button 0
    btn_raw = 4'hE;
    ticks(5);
    check("press_e5", {31'h0, o_io_btn[0]}, 32'h0);
    tick();
    check("press_e6",     {31'h0, o_io_btn[0]}, 32'h1);
    check("press_e6_pls", {28'h0, o_btn_pulse}, 32'h1);
    tick();
    check("press_e7_pls", {28'h0, o_btn_pulse}, 32'h0);
    btn_raw = 4'hF;
    ticks(5);
    check("rel_e5", {31'h0, o_io_btn[0]}, 32'h1);
    tick();
    check("rel_e6",     {31'h0, o_io_btn[0]}, 32'h0);
    check("rel_e6_pls", {28'h0, o_btn_pulse}, 32'h0);
    ticks(4);

    // Bounce on button 2: raw 0,1,0,1 then held released
    for (int i = 0; i < 4; i++) begin
      btn_raw[2] = i[0];
      tick();
      check("bounce_btn", {31'h0, o_io_btn[2]}, 32'h0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bounce_btn", {31'h0, o_io_btn[2]}, 32'h0);
      check("bounce_pls", {28'h0, o_btn_pulse}, 32'h0);
    end

    // Switch word atomicity and glitch rejection
    sw_raw = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sw_wait", o_io_sw, 32'h0);
    end
    tick();
    check("sw_e6", o_io_sw, 32'h1234_5678);
    ticks(3);
    sw_raw = 32'hA5A5_A5A5;
    ticks(2);
    sw_raw = 32'h1234_5678;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("sw_glitch", o_io_sw, 32'h1234_5678);
    end

    // Reset in the middle of a button 3 debounce
    btn_raw[3] = 1'b0;
    ticks(3);
    assert_reset();
    #1;
    check("async_rst_sw",  o_io_sw, 32'h0);
    check("async_rst_btn", {28'h0, o_io_btn}, 32'h0);
    @(negedge clk);
    release_reset();
    ticks(5);
    check("rstmid_e5", {31'h0, o_io_btn[3]}, 32'h0);
    tick();
    check("rstmid_e6",     {31'h0, o_io_btn[3]}, 32'h1);
    check("rstmid_e6_pls", {28'h0, o_btn_pulse}, 32'h8);
    tick();
    check("rstmid_e7_pls", {28'h0, o_btn_pulse}, 32'h0);

    btn_raw[3] = 1'b1;
    ticks(10);

    // Independent channels: button 1, then button 3 two cycles later, plus a switch change
    btn_raw[1] = 1'b0;
    sw_raw     = 32'hCAFE_0001;
    ticks(2);
    btn_raw[3] = 1'b0;
    ticks(3);
    check("ind_e5_btn", {28'h0, o_io_btn}, 32'h0);
    tick();
    check("ind_e6_btn", {28'h0, o_io_btn}, 32'h2);
    check("ind_e6_pls", {28'h0, o_btn_pulse}, 32'h2);
    check("ind_e6_sw",  o_io_sw, 32'hCAFE_0001);
    tick();
    check("ind_e7_btn", {28'h0, o_io_btn}, 32'h2);
    check("ind_e7_pls", {28'h0, o_btn_pulse}, 32'h0);
    tick();
    check("ind_e8_btn", {28'h0, o_io_btn}, 32'hA);
    check("ind_e8_pls", {28'h0, o_btn_pulse}, 32'h8);

    // Randomized phase, checked by the scoreboard only
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        idx = $urandom_range(0, 3);
        btn_raw[idx] = ~btn_raw[idx];
      end
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 1) == 1) sw_raw = $urandom;
        else sw_raw = sw_raw ^ (32'h1 << $urandom_range(0, 31));
      end
      if (c == 300) begin
        assert_reset();
        ticks(2);
        release_reset();
      end
      tick();
    end

    ticks(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Front end for the memory-mapped input peripheral. Takes raw, asynchronous board switches and push-buttons, synchronises them to the core clock and debounces them.
- Produces the clean 32-bit switch word and 4-bit button nibble that the load-side input buffer returns at 0x7800–0x781F.
- Also produces one-cycle press pulses for later interrupt or sticky-flag logic.

Parameters:
- SYNC_STAGES, 2, synchroniser depth per bit; legal values ≥2.
- BTN_DB_CYCLES, 500000, consecutive stable cycles required before a button output changes (10 ms at 50 MHz); legal values ≥1.
- SW_DB_CYCLES, 500000, consecutive stable cycles required before the switch word changes; legal values ≥1.
- BTN_ACTIVE_LOW, 1, when 1 the raw buttons are inverted at the input so that o_io_btn=1 means pressed.

Ports:
- i_clk  input  1  core clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_sw_raw  input  32  raw switch levels, asynchronous to i_clk.
- i_btn_raw  input  4  raw button levels, asynchronous to i_clk.
- o_io_sw  output  32  debounced switch word, feeds the input buffer's i_io_sw.
- o_io_btn  output  4  debounced, polarity-corrected buttons, feeds i_io_btn.
- o_btn_pulse  output  4  one-cycle high on each debounced press (0→1 of o_io_btn).

Behaviour:
- Reset: i_rst_n=0 clears every flop at once, independent of the clock. This covers synchroniser stages, counters, candidate register, o_io_sw, o_io_btn and the btn_prev copy. Outputs read 0 while reset is held.
- Reset mid-debounce: any partial count is discarded. After release, debounce restarts from 0 against the current raw inputs.
- Polarity: when BTN_ACTIVE_LOW=1, i_btn_raw is inverted before the first synchroniser flop. Synchroniser flops therefore reset to the "released" level, 0.
- Synchroniser: a chain of SYNC_STAGES flops per bit, with no logic between stages. Its output is btn_s[3:0] and sw_s[31:0].
- Button debounce, independent per bit k, with counter bcnt[k] of width $clog2(BTN_DB_CYCLES+1):
  - If btn_s[k]==o_io_btn[k]: bcnt[k] is set to 0.
  - Else if bcnt[k]==BTN_DB_CYCLES-1: o_io_btn[k] takes btn_s[k] and bcnt[k] is set to 0.
  - Else: bcnt[k] increments.
  - Latency: after a clean raw change, o_io_btn[k] updates at rising edge SYNC_STAGES+BTN_DB_CYCLES. Edge 1 is the first edge that samples the new raw level.
  - Glitch rejection: a single cycle where btn_s[k] equals the output restarts the count.
- Switch debounce, one group counter for the whole word (scnt) plus a 32-bit candidate register sw_c:
  - If sw_s!=sw_c: sw_c takes sw_s and scnt is set to 0.
  - Else if sw_c!=o_io_sw: if scnt==SW_DB_CYCLES-1, o_io_sw takes sw_c and scnt is set to 0; otherwise scnt increments.
  - Else: scnt is set to 0.
  - Latency is SYNC_STAGES+1+SW_DB_CYCLES edges. All 32 bits update on the same edge, so the core never sees a partially updated word.
  - Any bit change inside the window restarts the window for the whole word.
- Press pulse: btn_prev is a registered copy of o_io_btn, and o_btn_pulse = o_io_btn & ~btn_prev.
  - The pulse is high exactly during the first cycle o_io_btn[k] is 1.
  - There is no pulse on release, and no pulse after reset if the button is released.
- Simultaneous events: all button bits and the switch word run independently and may update on the same edge.
- Counter overflow: not possible, because each counter saturates at its DB_CYCLES-1 by construction.
- Purely synchronous outputs: there is no combinational path from any raw input to any output.

Test Plan:
All scenarios use SYNC_STAGES=2, BTN_DB_CYCLES=4, SW_DB_CYCLES=3, BTN_ACTIVE_LOW=1.
- Reset: hold i_rst_n=0 with i_sw_raw=0xFFFFFFFF and i_btn_raw=0x0 (all pressed) -> all outputs 0. Release reset -> o_io_btn=0xF at edge 6 and o_io_sw=0xFFFFFFFF at edge 6. o_btn_pulse=0xF for exactly 1 cycle.
- Clean press: drive i_btn_raw[0] 1→0 and hold -> o_io_btn[0]=1 at edge 6, not before. o_btn_pulse[0]=1 for exactly 1 cycle. Release (0→1) -> o_io_btn[0]=0 at edge 6 with no pulse.
- Bounce rejection: drive i_btn_raw[2] with the sequence 0,1,0,1 (1 cycle each), then hold 1 -> o_io_btn[2] stays 0 and o_btn_pulse stays 0 throughout.
- Switch word atomicity: change i_sw_raw from 0x00000000 to 0x12345678 and hold -> o_io_sw jumps to 0x12345678 at edge 6, with no intermediate value. Change to 0xA5A5A5A5 for 2 cycles, then back to 0x12345678 -> o_io_sw stays 0x12345678.
- Reset mid-debounce: start a button-3 press, assert i_rst_n=0 after 3 edges, release reset 2 cycles later with the press still held -> o_io_btn[3]=0 until 6 edges after release, then 1 with a single pulse.
- Independent channels: press buttons 1 and 3 two cycles apart while the switch word changes -> each output updates at its own computed edge. Pulses do not merge.
